// File: rtl/pe2_ntt_sched.sv
// pe2_ntt_sched: pass/group scheduler driving a radix-4 PE2 butterfly array through an NTT/INTT,
// issuing read/twiddle addresses and replaying them as write-backs after the datapath latency.
module pe2_ntt_sched #(
    parameter int N_LOG    = 8,
    parameter int PIPE_LAT = 9,
    parameter int TW_AW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    output logic                 rd_en,
    output logic [4*N_LOG-1:0]   rd_addr,
    output logic [TW_AW-1:0]     tw_addr,
    output logic                 pe_sel,
    output logic                 wr_en,
    output logic [4*N_LOG-1:0]   wr_addr,
    output logic                 busy,
    output logic                 done
);
    localparam int N  = 1 << N_LOG;
    localparam int G  = N / 4;
    localparam int P  = N_LOG / 2;
    localparam int SW = $clog2(N_LOG);
    localparam int CW = $clog2(PIPE_LAT + 1);
    localparam int AW = 4 * N_LOG;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t             state, state_n;
    logic [N_LOG-1:0]   g, g_n, p, p_n;
    logic [SW-1:0]      slg, slg_n;
    logic [TW_AW-1:0]   tb, tb_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               pe_sel_n;
    logic [N_LOG-1:0]   s_v, j, k, base;
    logic [AW-1:0]      addr_n;
    logic [TW_AW-1:0]   tw_n;
    logic [AW:0]        dl [PIPE_LAT];

    always_comb begin
        state_n  = state;
        g_n      = g;
        p_n      = p;
        slg_n    = slg;
        tb_n     = tb;
        cnt_n    = cnt;
        pe_sel_n = pe_sel;
        if (state == IDLE && start) begin
            state_n  = ISSUE;
            g_n      = '0;
            p_n      = '0;
            pe_sel_n = mode;
            slg_n    = mode ? '0 : SW'(N_LOG - 2);
            tb_n     = mode ? TW_AW'((N - 1) / 3) : '0;
        end else if (state == ISSUE) begin
            g_n = g + N_LOG'(1);
            if (g == N_LOG'(G - 1)) begin
                state_n = DRAIN;
                cnt_n   = '0;
            end
        end else if (state == DRAIN) begin
            cnt_n = cnt + CW'(1);
            if (cnt == CW'(PIPE_LAT - 1)) begin
                state_n = (p == N_LOG'(P - 1)) ? FIN : ISSUE;
                if (p != N_LOG'(P - 1)) begin
                    p_n   = p + N_LOG'(1);
                    g_n   = '0;
                    slg_n = pe_sel ? slg + SW'(2) : slg - SW'(2);
                    // next twiddle block starts after every distinct k of this pass
                    tb_n  = tb + TW_AW'(G >> slg);
                end
            end
        end else if (state == FIN) begin
            state_n = IDLE;
        end
    end

    always_comb begin
        s_v  = N_LOG'(1) << slg;
        j    = g & (s_v - N_LOG'(1));
        k    = g >> slg;
        base = ((k << slg) << 2) | j;
        for (int i = 0; i < 4; i++)
            addr_n[i*N_LOG +: N_LOG] = base + (N_LOG'(i) << slg);
        tw_n = tb + TW_AW'(k);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            g       <= '0;
            p       <= '0;
            slg     <= '0;
            tb      <= '0;
            cnt     <= '0;
            pe_sel  <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            tw_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++)
                dl[i] <= '0;
        end else begin
            state  <= state_n;
            g      <= g_n;
            p      <= p_n;
            slg    <= slg_n;
            tb     <= tb_n;
            cnt    <= cnt_n;
            pe_sel <= pe_sel_n;
            rd_en  <= state == ISSUE;
            if (state == ISSUE) begin
                rd_addr <= addr_n;
                tw_addr <= tw_n;
            end
            busy  <= state == ISSUE || state == DRAIN;
            done  <= state == FIN;
            dl[0] <= {rd_en, rd_addr};
            for (int i = 1; i < PIPE_LAT; i++)
                dl[i] <= dl[i-1];
        end
    end

    assign {wr_en, wr_addr} = dl[PIPE_LAT-1];
endmodule

// File: doc/pe2_ntt_sched.md
Name: pe2_ntt_sched

Overview:
Pass/group scheduler that sequences a radix-4 butterfly array built from PE2 units through a full N-point NTT (mode 0) or INTT (mode 1).
- Generates four coefficient read addresses per group per cycle, plus the twiddle ROM address and the PE mode select.
- Produces write-back enables and addresses delayed by the fixed datapath latency.
- Inserts a drain gap between passes so a pass never reads data that has not yet been written back.
- Sits between the top-level NTT FSM and the coefficient RAM banks / twiddle ROM.

Parameters:
N_LOG, 8, log2 of transform size N (even; N=256 default)
PIPE_LAT, 9, cycles from rd_en to matching write-back (read + PE2 pipeline)
TW_AW, 8, twiddle ROM address width (must hold 2*(N-1)/3 entries)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  1  0=NTT, 1=INTT; sampled with start
rd_en  out  1  group read issue
rd_addr  out  4*N_LOG  lane i address at [i*N_LOG +: N_LOG]
tw_addr  out  TW_AW  twiddle ROM address for current group
pe_sel  out  1  PE2 sel; equals latched mode for the whole operation
wr_en  out  1  write-back strobe
wr_addr  out  4*N_LOG  write-back addresses, same packing as rd_addr
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; delay line cleared.
- Reset mid-operation: outputs return to 0 on the next edge; in-flight writes are discarded.
- Start handling:
  - State IDLE, start=1: latch mode; go to ISSUE with pass p=0, group g=0; busy=1 next cycle.
  - start while busy is ignored.
- Constants: P = N_LOG/2 passes; G = N/4 groups per pass.
- Stride per pass:
  - NTT: s = 4^(P-1-p), i.e. 64, 16, 4, 1 at default.
  - INTT: s = 4^p, i.e. 1, 4, 16, 64.
- Group decode: j = g mod s; k = g div s; base = k*4s + j.
- Read addresses: lane i = base + i*s (i = 0..3).
- Twiddle address: tw_addr = TB(p) + k, where:
  - NTT: TB(p) = (4^p - 1)/3, i.e. 0, 1, 5, 21.
  - INTT: TB(p) = (N-1)/3 + sum of earlier pass group counts, i.e. 85, 149, 165, 169.
- Address outputs are registered; rd_en, rd_addr and tw_addr are valid in the same cycle.
- States:
  - ISSUE: rd_en=1 each cycle; g increments. After g = G-1, go to DRAIN.
  - DRAIN: rd_en=0 for exactly PIPE_LAT cycles. Then:
    - if p < P-1: p++, g=0, go to ISSUE;
    - else go to FIN.
  - FIN: done=1, busy=0 for one cycle, then IDLE.
- Write-back delay line: {rd_en, rd_addr} is delayed by exactly PIPE_LAT cycles to produce {wr_en, wr_addr}.
  - wr_en is never high during ISSUE of the following pass.
- Timing, with the accepting edge at cycle 0 (defaults N=256, PIPE_LAT=9):
  - Pass p reads in cycles 1+p(64+L) .. 64+p(64+L), where L = PIPE_LAT.
  - Final write at cycle 4(64+L) = 292.
  - done at cycle 293.
  - Total rd_en cycles = 256; total wr_en cycles = 256.
- pe_sel is held constant from the accepting edge until FIN, then holds its value.

Test Plan:
- NTT start at cycle 0:
  - cycle 1: rd_addr = {192,128,64,0}, tw_addr=0, pe_sel=0.
  - cycle 2: rd_addr = {193,129,65,1}.
  - cycle 10: wr_en=1, wr_addr = {192,128,64,0}.
- NTT pass boundary:
  - rd_en low in cycles 65–73.
  - cycle 74: rd_addr = {48,32,16,0}, tw_addr=1.
  - cycle 90 (g=16): rd_addr = {112,96,80,64}, tw_addr=2.
- INTT run:
  - cycle 1: rd_addr = {3,2,1,0}, tw_addr=85, pe_sel=1.
  - cycle 2: rd_addr = {7,6,5,4}, tw_addr=86.
  - Last pass, first group: rd_addr = {192,128,64,0}, tw_addr=169.
- Completion:
  - wr_en count = 256, rd_en count = 256.
  - Final wr_en at cycle 292; done single pulse at 293; busy falls at 293.
  - Each address appears in wr_addr exactly 4 times.
- start asserted at cycles 5 and 150 during an NTT: ignored; schedule and done cycle unchanged. start with mode=1 after done: INTT runs normally.
- rst=1 at cycle 40 (mid-ISSUE): rd_en, wr_en, busy = 0 from cycle 41. Restart at cycle 45 reproduces cycle-1 addresses at cycle 46.
